// File: rtl/matmul_pkg.sv
// Shared types and sizes for the matmul sequencing controller and its datapath.
package matmul_pkg;

    localparam int MAT_WORDS  = 16;
    localparam int VEC_WORDS  = 4;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN
    } mseq_state_t;

endpackage

// File: rtl/matmul_seq_matmul.sv
// 4x4 matrix-vector datapath: x[i] = sum_j a[4i+j]*b[j], DW-bit truncated,
// delivered through a LATENCY-deep register pipeline.
module matmul
    import matmul_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MAT_WORDS*DW-1:0]    a,
    input  logic [VEC_WORDS*DW-1:0]    b,
    output logic [VEC_WORDS*DW-1:0]    x
);

    logic [VEC_WORDS*DW-1:0] prod;
    logic [VEC_WORDS*DW-1:0] pipe [LATENCY];
    logic [DW-1:0]           acc;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int unsigned i = 0; i < VEC_WORDS; i++) begin
            acc = '0;
            for (int unsigned j = 0; j < VEC_WORDS; j++) begin
                acc = acc + a[(i*VEC_WORDS+j)*DW +: DW] * b[j*DW +: DW];
            end
            prod[i*DW +: DW] = acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= prod;
            for (int unsigned k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign x = pipe[LATENCY-1];

endmodule

// File: rtl/matmul_seq.sv
// Valid/ready sequencer feeding the matmul datapath: loads A, then streams vectors.
// Optional MATMUL_SEQ_PERF_EN adds the vec_cnt completed-vector counter.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int MM_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_a,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [15:0]   vec_cnt
`endif
);

    mseq_state_t state;
    logic [DW-1:0] a_reg [MAT_WORDS];
    logic [DW-1:0] b_reg [VEC_WORDS];
    logic [DW-1:0] x_buf [VEC_WORDS];
    logic [3:0]    idx;
    logic [3:0]    lat_cnt;
    logic          a_pend;

    logic [MAT_WORDS*DW-1:0] a_flat;
    logic [VEC_WORDS*DW-1:0] b_flat;
    logic [VEC_WORDS*DW-1:0] mm_x;
    logic                    mm_rst;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int unsigned k = 0; k < MAT_WORDS; k++) a_flat[k*DW +: DW] = a_reg[k];
        for (int unsigned k = 0; k < VEC_WORDS; k++) b_flat[k*DW +: DW] = b_reg[k];
    end

    assign mm_rst = ~rst;

    matmul #(
        .DW      (DW),
        .LATENCY (MM_LATENCY)
    ) u_matmul (
        .clk (clk),
        .rst (mm_rst),
        .a   (a_flat),
        .b   (b_flat),
        .x   (mm_x)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            lat_cnt   <= '0;
            a_pend    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int unsigned k = 0; k < MAT_WORDS; k++) a_reg[k] <= '0;
            for (int unsigned k = 0; k < VEC_WORDS; k++) begin
                b_reg[k] <= '0;
                x_buf[k] <= '0;
            end
`ifdef MATMUL_SEQ_PERF_EN
            vec_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_a) begin
                        state    <= LOAD_A;
                        idx      <= '0;
                        a_pend   <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (load_a) a_pend <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_reg[idx] <= in_data;
                        if (idx == 4'(MAT_WORDS - 1)) begin
                            state <= LOAD_B;
                            idx   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                LOAD_B: begin
                    // A reload only preempts a vector that has not started.
                    if (load_a && idx == 4'd0) begin
                        state  <= LOAD_A;
                        a_pend <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        if (load_a) a_pend <= 1'b1;
                        if (in_valid && in_ready) begin
                            b_reg[idx[1:0]] <= in_data;
                            busy            <= 1'b1;
                            if (idx == 4'(VEC_WORDS - 1)) begin
                                state    <= COMPUTE;
                                lat_cnt  <= 4'(MM_LATENCY);
                                in_ready <= 1'b0;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                COMPUTE: begin
                    if (load_a) a_pend <= 1'b1;
                    if (lat_cnt == 4'd0) begin
                        for (int unsigned k = 0; k < VEC_WORDS; k++) x_buf[k] <= mm_x[k*DW +: DW];
                        out_data  <= mm_x[DW-1:0];
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                        idx       <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DRAIN: begin
                    if (load_a) a_pend <= 1'b1;
                    if (out_valid && out_ready) begin
                        if (idx == 4'(VEC_WORDS - 1)) begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            idx       <= '0;
`ifdef MATMUL_SEQ_PERF_EN
                            vec_cnt   <= vec_cnt + 16'd1;
`endif
                            // A load_a landing on the final handshake still counts as pending.
                            if (a_pend || load_a) begin
                                state  <= LOAD_A;
                                a_pend <= 1'b0;
                                busy   <= 1'b1;
                            end else begin
                                state <= LOAD_B;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx      <= idx + 4'd1;
                            out_data <= x_buf[idx[1:0] + 2'd1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
